reuse_ctrl_seq: RTL and testbench



---
 rtl/reuse_ctrl_pkg.sv | 35 +++
 rtl/sched_fifo.sv | 52 +++++
 rtl/reuse_ctrl_seq.sv | 146 ++++++++++++++
 tb/tb_reuse_ctrl_seq.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/reuse_ctrl_pkg.sv
// Shared parameters, entry field layout and FSM states for the
// multiplier-reuse control sequencer.
package reuse_ctrl_pkg;

    localparam int TN           = 16;
    localparam int OUT_LIMIT    = 2;
    localparam int IN_LIMIT     = 3;
    localparam int ADDR_SIZE    = 2;
    localparam int L1_SEL_WIDTH = 4;
    localparam int L2_SEL_WIDTH = 6;
    localparam int RPT_WIDTH    = 4;
    localparam int FIFO_DEPTH   = 4;

    localparam int L1_W   = TN * OUT_LIMIT * L1_SEL_WIDTH;
    localparam int L2_W   = TN * IN_LIMIT * L2_SEL_WIDTH;
    localparam int ADDR_W = TN * ADDR_SIZE;
    localparam int WEN_W  = TN;

    // entry layout, LSB first: l1, l2, rd, wr, wen, rpt, last
    localparam int L1_LSB   = 0;
    localparam int L2_LSB   = L1_LSB + L1_W;
    localparam int RD_LSB   = L2_LSB + L2_W;
    localparam int WR_LSB   = RD_LSB + ADDR_W;
    localparam int WEN_LSB  = WR_LSB + ADDR_W;
    localparam int RPT_LSB  = WEN_LSB + WEN_W;
    localparam int LAST_LSB = RPT_LSB + RPT_WIDTH;
    localparam int ENTRY_W  = LAST_LSB + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_e;

endpackage

// File: rtl/sched_fifo.sv
// Synchronous first-word fall-through FIFO for reuse-schedule entries.
// Depth must be a power of two.
module sched_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] din_i,
    output logic [W-1:0] head_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wp_q;
    logic [AW-1:0] rp_q;
    logic [AW:0]   cnt_q;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem_q[rp_q];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wp_q <= wp_q + AW'(1);
            if (do_pop)  rp_q <= rp_q + AW'(1);
            unique case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
                2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wp_q] <= din_i;
    end

endmodule

// File: rtl/reuse_ctrl_seq.sv
// Replays buffered reuse-schedule entries as registered control words
// for the NFU-2A mux trees, partial-product buffers and NFU-2B.
module reuse_ctrl_seq
    import reuse_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_start,
    input  logic               i_sched_valid,
    output logic               o_sched_ready,
    input  logic [ENTRY_W-1:0] i_sched_entry,
    input  logic               i_nfu1_valid,
    output logic [L1_W-1:0]    o_l1_sel_lines,
    output logic [L2_W-1:0]    o_l2_sel_lines,
    output logic [ADDR_W-1:0]  o_buf_read_addr,
    output logic [ADDR_W-1:0]  o_buf_write_addr,
    output logic [WEN_W-1:0]   o_write_en,
    output logic               o_ctrl_valid,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_underrun
);

    state_e               state_q, state_d;
    logic [RPT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 fin_q, fin_d;
    logic                 und_q, und_d;
    logic                 vld_q, vld_d;
    logic [WEN_W-1:0]     wen_q, wen_d;
    logic [L1_W-1:0]      l1_q, l1_d;
    logic [L2_W-1:0]      l2_q, l2_d;
    logic [ADDR_W-1:0]    rd_q, rd_d;
    logic [ADDR_W-1:0]    wr_q, wr_d;

    logic [ENTRY_W-1:0]   head;
    logic                 full;
    logic                 empty;
    logic                 push;
    logic                 pop;
    logic                 beat;
    logic                 issue;
    logic                 underrun;

    assign o_sched_ready = rst_n && !full;
    assign push          = i_sched_valid && o_sched_ready;

    // fin_q marks the cycle the final word is on the outputs; beats then wait
    assign beat     = i_nfu1_valid && (state_q == ST_RUN) && !fin_q;
    assign issue    = beat && !empty;
    assign underrun = beat && empty;
    assign pop      = issue && (cnt_q == head[RPT_LSB +: RPT_WIDTH]);

    sched_fifo #(
        .W     (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   (i_sched_entry),
        .head_o  (head),
        .full_o  (full),
        .empty_o (empty)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fin_d   = fin_q;
        und_d   = und_q;
        vld_d   = beat;
        wen_d   = '0;
        l1_d    = l1_q;
        l2_d    = l2_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        unique case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d = ST_RUN;
                    und_d   = 1'b0;
                end
            end
            ST_RUN: begin
                if (fin_q) begin
                    state_d = ST_DONE;
                    fin_d   = 1'b0;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (underrun) und_d = 1'b1;
        if (issue) begin
            l1_d  = head[L1_LSB +: L1_W];
            l2_d  = head[L2_LSB +: L2_W];
            rd_d  = head[RD_LSB +: ADDR_W];
            wr_d  = head[WR_LSB +: ADDR_W];
            wen_d = head[WEN_LSB +: WEN_W];
            if (pop) begin
                cnt_d = '0;
                fin_d = head[LAST_LSB];
            end else begin
                cnt_d = cnt_q + RPT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            fin_q   <= 1'b0;
            und_q   <= 1'b0;
            vld_q   <= 1'b0;
            wen_q   <= '0;
            l1_q    <= '0;
            l2_q    <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fin_q   <= fin_d;
            und_q   <= und_d;
            vld_q   <= vld_d;
            wen_q   <= wen_d;
            l1_q    <= l1_d;
            l2_q    <= l2_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
        end
    end

    assign o_l1_sel_lines   = l1_q;
    assign o_l2_sel_lines   = l2_q;
    assign o_buf_read_addr  = rd_q;
    assign o_buf_write_addr = wr_q;
    assign o_write_en       = wen_q;
    assign o_ctrl_valid     = vld_q;
    assign o_busy           = (state_q != ST_IDLE);
    assign o_done           = (state_q == ST_DONE);
    assign o_underrun       = und_q;

endmodule

// File: tb/tb_reuse_ctrl_seq.sv
// Bench for reuse_ctrl_seq: directed table, corner sequences and
// random traffic against a word-expansion reference model.
module tb_reuse_ctrl_seq;

    localparam int EW     = 501;
    localparam int P_L2   = 128;
    localparam int P_RD   = 416;
    localparam int P_WR   = 448;
    localparam int P_WEN  = 480;
    localparam int P_RPT  = 496;
    localparam int P_LAST = 500;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          sv;
    logic          nv;
    logic [EW-1:0] ent;
    logic          o_sched_ready;
    logic [127:0]  o_l1;
    logic [287:0]  o_l2;
    logic [31:0]   o_rd;
    logic [31:0]   o_wr;
    logic [15:0]   o_wen;
    logic          o_ctrl_valid;
    logic          o_busy;
    logic          o_done;
    logic          o_underrun;

    always #5 clk = ~clk;

    reuse_ctrl_seq dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_start          (start),
        .i_sched_valid    (sv),
        .o_sched_ready    (o_sched_ready),
        .i_sched_entry    (ent),
        .i_nfu1_valid     (nv),
        .o_l1_sel_lines   (o_l1),
        .o_l2_sel_lines   (o_l2),
        .o_buf_read_addr  (o_rd),
        .o_buf_write_addr (o_wr),
        .o_write_en       (o_wen),
        .o_ctrl_valid     (o_ctrl_valid),
        .o_busy           (o_busy),
        .o_done           (o_done),
        .o_underrun       (o_underrun)
    );

    int nvec = 0;
    int nbad = 0;

    task automatic chk(string name, logic [511:0] act, logic [511:0] exp);
        nvec++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    // model: each entry expands into rpt+1 words; a beat consumes one word
    typedef struct {
        logic [EW-1:0] e;
        bit            eoe;
    } word_t;

    word_t        mw[$];
    int           m_ents;
    int           m_ph;   // 0 idle, 1 run, 2 final word out, 3 done
    bit           m_vld;
    bit           m_und;
    logic [15:0]  m_wen;
    logic [127:0] m_l1;
    logic [287:0] m_l2;
    logic [31:0]  m_rd;
    logic [31:0]  m_wr;

    function automatic void model_edge();
        word_t w;
        bit    acc;
        int    rpt;
        if (!rst_n) begin
            mw.delete();
            m_ents = 0; m_ph = 0; m_vld = 0; m_und = 0;
            m_wen = '0; m_l1 = '0; m_l2 = '0; m_rd = '0; m_wr = '0;
            return;
        end
        acc   = sv && (m_ents < 4);
        m_vld = 0;
        m_wen = '0;
        if (nv && m_ph == 1) begin
            m_vld = 1;
            if (mw.size() == 0) begin
                m_und = 1;
            end else begin
                w = mw.pop_front();
                m_l1  = w.e[P_L2-1:0];
                m_l2  = w.e[P_RD-1:P_L2];
                m_rd  = w.e[P_WR-1:P_RD];
                m_wr  = w.e[P_WEN-1:P_WR];
                m_wen = w.e[P_RPT-1:P_WEN];
                if (w.eoe) m_ents--;
                if (w.eoe && w.e[P_LAST]) m_ph = 2;
            end
        end else begin
            case (m_ph)
                0: if (start) begin m_ph = 1; m_und = 0; end
                2: m_ph = 3;
                3: m_ph = 0;
                default: ;
            endcase
        end
        if (acc) begin
            rpt = int'(ent[P_LAST-1:P_RPT]);
            for (int k = 0; k <= rpt; k++) begin
                w.e   = ent;
                w.eoe = (k == rpt);
                mw.push_back(w);
            end
            m_ents++;
        end
    endfunction

    task automatic check_all();
        chk("valid", o_ctrl_valid, m_vld);
        chk("wen", o_wen, m_wen);
        chk("l1_sel", o_l1, m_l1);
        chk("l2_sel", o_l2, m_l2);
        chk("rd_addr", o_rd, m_rd);
        chk("wr_addr", o_wr, m_wr);
        chk("busy", o_busy, m_ph != 0);
        chk("done", o_done, m_ph == 3);
        chk("underrun", o_underrun, m_und);
        chk("ready", o_sched_ready, rst_n && (m_ents < 4));
    endtask

    task automatic step(bit r, bit s, bit p, logic [EW-1:0] e, bit b);
        rst_n = r; start = s; sv = p; ent = e; nv = b;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
        @(negedge clk);
    endtask

    function automatic logic [EW-1:0] mk(int seed, int rpt, bit last,
                                         logic [15:0] wen);
        logic [EW-1:0] e;
        e = '0;
        for (int k = 0; k < 15; k++)
            e[k*32 +: 32] = (seed * 32'h9E3779B1) ^ (k * 32'h01010101);
        e[P_WEN +: 16] = wen;
        e[P_RPT +: 4]  = rpt[3:0];
        e[P_LAST]      = last;
        return e;
    endfunction

    typedef struct {
        bit r, s, p;
        int seed, rpt;
        bit last, b;
        bit xv, xb, xd, xu, xr;
    } vec_t;

    vec_t          tbl[24];
    vec_t          v;
    logic [15:0]   wv;
    logic [EW-1:0] e14;
    bit            rr;

    initial begin
        //         r  s  p seed rpt lst b  v  bsy dn un rdy
        tbl[0]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[2]  = '{1, 0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 1};
        tbl[3]  = '{1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1};
        tbl[4]  = '{1, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 1};
        tbl[5]  = '{1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1};
        tbl[6]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
        tbl[7]  = '{1, 0, 1, 2, 2, 0, 0, 0, 0, 0, 0, 1};
        tbl[8]  = '{1, 0, 1, 3, 0, 1, 0, 0, 0, 0, 0, 1};
        tbl[9]  = '{1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1};
        tbl[10] = '{1, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 1};
        tbl[11] = '{1, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 1};
        tbl[12] = '{1, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 1};
        tbl[13] = '{1, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 1};
        tbl[14] = '{1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1};
        tbl[15] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
        tbl[16] = '{1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1};
        tbl[17] = '{1, 0, 0, 0, 0, 0, 1, 1, 1, 0, 1, 1};
        tbl[18] = '{1, 0, 1, 4, 0, 1, 0, 0, 1, 0, 1, 1};
        tbl[19] = '{1, 0, 0, 0, 0, 0, 1, 1, 1, 0, 1, 1};
        tbl[20] = '{1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1};
        tbl[21] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
        tbl[22] = '{1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1};
        tbl[23] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

        rst_n = 0; start = 0; sv = 0; nv = 0; ent = '0;
        @(negedge clk);

        for (int i = 0; i < 24; i++) begin
            v  = tbl[i];
            wv = (v.seed == 1) ? 16'hFFFF : 16'(v.seed * 16'h1357);
            step(v.r, v.s, v.p, mk(v.seed, v.rpt, v.last, wv), v.b);
            chk("tbl_valid", o_ctrl_valid, v.xv);
            chk("tbl_busy", o_busy, v.xb);
            chk("tbl_done", o_done, v.xd);
            chk("tbl_underrun", o_underrun, v.xu);
            chk("tbl_ready", o_sched_ready, v.xr);
            if (i == 4) chk("basic_wen", o_wen, 16'hFFFF);
            if (i == 17) chk("und_wen", o_wen, 16'h0);
        end

        step(1, 0, 0, '0, 0);
        step(1, 0, 0, '0, 1);
        chk("idle_beat", o_ctrl_valid, 1'b0);

        for (int k = 0; k < 4; k++)
            step(1, 0, 1, mk(10 + k, 0, 0, 16'(16'h0F0F << k)), 0);
        chk("bp_full", o_sched_ready, 1'b0);
        e14 = mk(14, 0, 0, 16'hA5A5);
        step(1, 0, 1, e14, 0);
        chk("bp_hold", o_sched_ready, 1'b0);
        step(1, 1, 1, e14, 0);
        step(1, 0, 1, e14, 1);
        chk("bp_free", o_sched_ready, 1'b1);
        chk("bp_word", o_l1, mk(10, 0, 0, 16'h0F0F) & {{373{1'b0}}, {128{1'b1}}});
        step(1, 0, 1, e14, 0);
        chk("bp_refill", o_sched_ready, 1'b0);

        step(1, 1, 0, '0, 0);
        step(1, 1, 0, '0, 1);
        step(1, 0, 0, '0, 0);
        step(0, 0, 0, '0, 0);
        chk("rst_valid", o_ctrl_valid, 1'b0);
        chk("rst_l2", o_l2, '0);
        chk("rst_busy", o_busy, 1'b0);
        chk("rst_ready", o_sched_ready, 1'b0);
        step(1, 0, 0, '0, 0);
        chk("rst_nodone", o_done, 1'b0);
        step(1, 1, 0, '0, 0);
        step(1, 0, 0, '0, 1);
        chk("rst_flushed", o_underrun, 1'b1);
        step(0, 0, 0, '0, 0);

        for (int i = 0; i < 3000; i++) begin
            rr = ($urandom_range(0, 299) != 0);
            step(rr, $urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0,
                 mk(int'($urandom), int'($urandom_range(0, 3)),
                    $urandom_range(0, 3) == 0, 16'($urandom)),
                 $urandom_range(0, 1) == 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
